// File: rtl/acq_pkg.sv
// Shared encodings for the capture sequencer: states, ctrl word fields, status byte.
package acq_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned CTRL_W     = 32;
    localparam int unsigned STATUS_W   = 8;

    // ctrl word field positions
    localparam int unsigned TRIG_LVL_LSB = 0;
    localparam int unsigned TRIG_LVL_MSB = 15;
    localparam int unsigned ARM_BIT      = 16;
    localparam int unsigned ABORT_BIT    = 17;
    localparam int unsigned EDGE_BIT     = 18;
    localparam int unsigned FORCE_BIT    = 19;
    localparam int unsigned POST_LSB     = 20;
    localparam int unsigned POST_W       = 12;
    localparam int unsigned LVL_W        = TRIG_LVL_MSB - TRIG_LVL_LSB + 1;

    // status byte layout
    localparam int unsigned STAT_ARMED_BIT = 0;
    localparam int unsigned STAT_TRIG_BIT  = 1;
    localparam int unsigned STAT_DONE_BIT  = 2;
    localparam int unsigned STAT_REJ_BIT   = 3;
    localparam int unsigned STAT_ID_LSB    = 4;
    localparam logic [3:0]  STATUS_ID      = 4'hA;

    // state encodings
    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_ARMED = 2'd1;
    localparam logic [1:0] ENC_POST  = 2'd2;
    localparam logic [1:0] ENC_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_ARMED = ENC_ARMED,
        ST_POST  = ENC_POST,
        ST_DONE  = ENC_DONE
    } acq_state_e;

    // capture configuration latched from the ctrl word
    typedef struct packed {
        logic [POST_W-1:0] post_count;
        logic              edge_fall;
        logic [LVL_W-1:0]  trig_level;
    } acq_cfg_t;

    // Assemble the SPI status byte from state and the sticky reject flag.
    function automatic logic [STATUS_W-1:0] status_word(acq_state_e st, logic rej);
        logic [STATUS_W-1:0] s;
        s = '0;
        s[STAT_ID_LSB +: 4]  = STATUS_ID;
        s[STAT_REJ_BIT]      = rej;
        s[STAT_DONE_BIT]     = (st == ST_DONE);
        s[STAT_TRIG_BIT]     = (st == ST_POST);
        s[STAT_ARMED_BIT]    = (st == ST_ARMED);
        return s;
    endfunction

endpackage

// File: rtl/acq_capture_controller_trigger.sv
// Level/edge trigger detector with one-sample history and force override.
module acq_trigger
    import acq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              edge_fall,
    input  logic              force_req,
    input  logic              enable,
    input  logic              clear,
    output logic              hit_c
);

    logic [DATA_W-1:0] prev_q;
    logic              hist_q;
    logic              take_c;
    logic              rise_c;
    logic              fall_c;

    assign take_c = enable & sample_valid;

    // Previous-sample history; cleared on arm so the first sample cannot trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            hist_q <= 1'b0;
        end else if (clear) begin
            hist_q <= 1'b0;
        end else if (take_c) begin
            prev_q <= sample_in;
            hist_q <= 1'b1;
        end
    end

    // Crossing compare against the programmed level.
    always_comb begin
        rise_c = (prev_q <  trig_level) && (sample_in >= trig_level);
        fall_c = (prev_q >= trig_level) && (sample_in <  trig_level);
        hit_c  = take_c & (force_req | (hist_q & (edge_fall ? fall_c : rise_c)));
    end

endmodule

// File: rtl/acq_capture_controller.sv
// Capture buffer sequencer: circular pre-trigger capture, trigger, post count, freeze.
module acq_capture_controller
    import acq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CTRL_W-1:0]   ctrl,
    input  logic                ctrl_stb,
    input  logic [DATA_W-1:0]   sample_in,
    input  logic                sample_valid,
    input  logic                spi_rd_active,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [ADDR_W-1:0]   trig_addr,
    output logic [STATUS_W-1:0] status
);

    acq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    acq_cfg_t          cfg_q, cfg_d;
    logic              force_q, force_d;
    logic              rej_q, rej_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;
    logic [ADDR_W-1:0] trig_addr_d;
    logic              trig_en_c;
    logic              trig_clear_c;
    logic              hit_c;
    logic              stb_abort_c;
    logic              stb_arm_c;
    logic              arm_rej_c;
    logic [ADDR_W-1:0] post_c;

    acq_trigger #(.DATA_W(DATA_W)) u_trigger (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .trig_level   (DATA_W'(cfg_q.trig_level)),
        .edge_fall    (cfg_q.edge_fall),
        .force_req    (force_q),
        .enable       (trig_en_c),
        .clear        (trig_clear_c),
        .hit_c        (hit_c)
    );

    // Next-state, pointer/counter and write-port decisions.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        cfg_d        = cfg_q;
        force_d      = force_q;
        rej_d        = rej_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;
        trig_addr_d  = trig_addr;
        trig_en_c    = 1'b0;
        trig_clear_c = 1'b0;
        post_c       = ADDR_W'(cfg_q.post_count);

        stb_abort_c = ctrl_stb & ctrl[ABORT_BIT];
        stb_arm_c   = ctrl_stb & ctrl[ARM_BIT] & ~ctrl[ABORT_BIT];
        // Arming from a quiescent state is refused while SPI streams the buffer.
        arm_rej_c   = stb_arm_c & spi_rd_active &
                      ((state_q == ST_IDLE) || (state_q == ST_DONE));

        if (ctrl_stb && !arm_rej_c) begin
            cfg_d.trig_level = ctrl[TRIG_LVL_MSB:TRIG_LVL_LSB];
            cfg_d.edge_fall  = ctrl[EDGE_BIT];
            cfg_d.post_count = ctrl[POST_LSB +: POST_W];
            rej_d            = 1'b0;
        end

        if (stb_abort_c) begin
            state_d = ST_IDLE;
            force_d = 1'b0;
        end else if (arm_rej_c) begin
            rej_d = 1'b1;
        end else if (stb_arm_c) begin
            state_d      = ST_ARMED;
            ptr_d        = '0;
            force_d      = 1'b0;
            trig_clear_c = 1'b1;
        end else begin
            if (ctrl_stb && ctrl[FORCE_BIT] && (state_q == ST_ARMED)) begin
                force_d = 1'b1;
            end
            case (state_q)
                ST_ARMED: begin
                    trig_en_c = 1'b1;
                    if (sample_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = sample_in;
                        ptr_d     = ptr_q + ADDR_W'(1);
                        if (hit_c) begin
                            trig_addr_d = ptr_q;
                            cnt_d       = post_c;
                            force_d     = 1'b0;
                            state_d     = (post_c == '0) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (sample_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = sample_in;
                        ptr_d     = ptr_q + ADDR_W'(1);
                        cnt_d     = cnt_q - ADDR_W'(1);
                        if (cnt_q == ADDR_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            cfg_q     <= '0;
            force_q   <= 1'b0;
            rej_q     <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            trig_addr <= '0;
            status    <= {STATUS_ID, 4'h0};
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            cfg_q     <= cfg_d;
            force_q   <= force_d;
            rej_q     <= rej_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            trig_addr <= trig_addr_d;
            status    <= status_word(state_q, rej_q);
        end
    end

endmodule

// File: tb/tb_acq_capture_controller.sv
// Scoreboard bench for acq_capture_controller: expected writes queued at stimulus time.
module tb_acq_capture_controller;

    logic        clk;
    logic        rst_n;
    logic [31:0] ctrl;
    logic        ctrl_stb;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        spi_rd_active;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic [11:0] trig_addr;
    logic [7:0]  status;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    int checks;
    int errors;

    acq_capture_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ctrl          (ctrl),
        .ctrl_stb      (ctrl_stb),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .spi_rd_active (spi_rd_active),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .trig_addr     (trig_addr),
        .status        (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [15:0] lvl, input logic arm, input logic abrt,
                                       input logic fe, input logic frc, input logic [11:0] post);
        return {post, frc, fe, abrt, arm, lvl};
    endfunction

    task automatic strobe(input logic [31:0] w);
        ctrl     = w;
        ctrl_stb = 1'b1;
        tick();
        ctrl_stb = 1'b0;
    endtask

    task automatic push(input int addr, input logic [15:0] d);
        wr_exp_t e;
        e.addr = 12'(addr);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        wr_exp_t e;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        ctrl          = '0;
        ctrl_stb      = 1'b0;
        sample_in     = '0;
        sample_valid  = 1'b0;
        spi_rd_active = 1'b0;

        // write monitor: every wr_en must match the head of the expected queue
        fork
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1 && wr_en === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                                 wr_addr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                        chk("wr_data", 32'(wr_data), 32'(e.data));
                    end
                end
            end
        join_none

        // reset values
        idle(3);
        chk("rst_status", 32'(status), 32'hA0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        chk("rst_trig_addr", 32'(trig_addr), 32'h0);
        rst_n = 1'b1;
        tick();

        // idle samples produce no writes
        for (int i = 0; i < 3; i++) begin
            sample_in = 16'(16'h1234 + i); sample_valid = 1'b1; tick();
        end
        sample_valid = 1'b0;
        idle(2);
        chk("idle_status", 32'(status), 32'hA0);

        // rising edge ramp, level 0x0800, post 4: trigger at addr 16, last write at 20
        strobe(mk(16'h0800, 1'b1, 1'b0, 1'b0, 1'b0, 12'd4));
        tick();
        chk("armed_status", 32'(status), 32'hA1);
        for (int i = 0; i < 25; i++) begin
            sample_in = 16'(16'h07F0 + i); sample_valid = 1'b1;
            if (i <= 20) push(i, 16'(16'h07F0 + i));
            tick();
        end
        sample_valid = 1'b0;
        idle(2);
        chk("ramp_trig_addr", 32'(trig_addr), 32'd16);
        chk("ramp_status", 32'(status), 32'hA4);

        // falling edge, level 0x0100, post 0: trigger sample is the last write
        strobe(mk(16'h0100, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0));
        tick();
        chk("fall_armed", 32'(status), 32'hA1);
        sample_in = 16'h0200; sample_valid = 1'b1; push(0, 16'h0200); tick();
        sample_in = 16'h0180; push(1, 16'h0180); tick();
        sample_in = 16'h00FF; push(2, 16'h00FF); tick();
        sample_in = 16'h0050; tick();
        sample_in = 16'h0010; tick();
        sample_valid = 1'b0;
        idle(2);
        chk("fall_trig_addr", 32'(trig_addr), 32'd2);
        chk("fall_status", 32'(status), 32'hA4);

        // arm refused while SPI streams the buffer
        spi_rd_active = 1'b1;
        strobe(mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0));
        tick();
        chk("rej_status", 32'(status), 32'hAC);
        sample_in = 16'h7777; sample_valid = 1'b1; tick(); tick();
        sample_valid = 1'b0;
        idle(2);
        chk("rej_trig_addr", 32'(trig_addr), 32'd2);
        spi_rd_active = 1'b0;

        // wrap: level 0xFFFF never reached for 5000 samples, then force with post 0xFFF
        strobe(mk(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0));
        tick();
        chk("rearm_status", 32'(status), 32'hA1);
        for (int k = 0; k < 5000; k++) begin
            sample_in = 16'(k); sample_valid = 1'b1; push(k % 4096, 16'(k));
            tick();
        end
        sample_valid = 1'b0;
        chk("wrap_pre_status", 32'(status), 32'hA1);
        strobe(mk(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 12'hFFF));
        for (int j = 0; j < 4100; j++) begin
            sample_in = 16'(16'h1000 + j); sample_valid = 1'b1;
            if (j < 4096) push((904 + j) % 4096, 16'(16'h1000 + j));
            tick();
        end
        sample_valid = 1'b0;
        idle(2);
        chk("wrap_trig_addr", 32'(trig_addr), 32'd904);
        chk("wrap_status", 32'(status), 32'hA4);

        // arm+abort in one word during POST: back to IDLE, no writes, trig_addr held
        strobe(mk(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 12'd10));
        sample_in = 16'h0000; sample_valid = 1'b1; push(0, 16'h0000); tick();
        sample_in = 16'h0020; push(1, 16'h0020); tick();
        sample_in = 16'h0021; push(2, 16'h0021); tick();
        sample_in = 16'h0022;
        ctrl = mk(16'h0010, 1'b1, 1'b1, 1'b0, 1'b0, 12'd10); ctrl_stb = 1'b1;
        tick();
        ctrl_stb = 1'b0;
        tick(); tick();
        sample_valid = 1'b0;
        idle(2);
        chk("abort_status", 32'(status), 32'hA0);
        chk("abort_trig_addr", 32'(trig_addr), 32'd1);

        // async reset in the middle of POST
        strobe(mk(16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 12'd10));
        sample_in = 16'h0000; sample_valid = 1'b1; push(0, 16'h0000); tick();
        sample_in = 16'h0030; push(1, 16'h0030); tick();
        sample_in = 16'h0031; push(2, 16'h0031); tick();
        sample_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("post_status", 32'(status), 32'hA2);
        chk("post_trig_addr", 32'(trig_addr), 32'd1);
        sample_in = 16'h0032; sample_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", 32'(wr_en), 32'h0);
        chk("arst_wr_addr", 32'(wr_addr), 32'h0);
        chk("arst_wr_data", 32'(wr_data), 32'h0);
        chk("arst_trig_addr", 32'(trig_addr), 32'h0);
        chk("arst_status", 32'(status), 32'hA0);
        sample_valid = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        chk("post_rst_status", 32'(status), 32'hA0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acq_capture_controller.md
# acq_capture_controller

Sequencer for the 4096 x 16 capture buffer that the SPI memory reader streams out. Takes a 32-bit control word written over SPI, arms a circular pre-trigger capture of incoming samples, detects a level trigger, records a programmable number of post-trigger samples, then freezes the buffer and reports status for the SPI status byte. Owns the buffer write port. Holds off re-arming while the SPI side is streaming the buffer.

## Interface
- ADDR_W, 12, buffer address width (4096 words)
- DATA_W, 16, sample/word width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ctrl  in  32  control word from SPI register: [15:0] trig_level, [16] arm, [17] abort, [18] edge (0 rising, 1 falling), [19] force, [31:20] post_count
- ctrl_stb  in  1  one-cycle pulse when ctrl is rewritten
- sample_in  in  DATA_W  sample data, unsigned
- sample_valid  in  1  sample_in valid this cycle
- spi_rd_active  in  1  high while SPI memory read transaction is open (nCS low, mem command)
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  buffer write address
- wr_data  out  DATA_W  buffer write data
- trig_addr  out  ADDR_W  address holding the trigger sample
- status  out  8  {4'hA, arm_rejected, done, triggered, armed}

## Operation
- States: IDLE, ARMED, POST, DONE. Reset -> IDLE.
- ctrl is sampled only on ctrl_stb. Abort wins over arm in the same word. Force is ignored unless the state is ARMED.
- IDLE/DONE + arm, spi_rd_active=0 -> ARMED. wr_addr pointer clears to 0. Trigger history is invalidated. arm_rejected clears.
- IDLE/DONE + arm, spi_rd_active=1 -> no state change, arm_rejected=1 (sticky until the next accepted ctrl_stb).
- arm while ARMED/POST restarts ARMED with the pointer cleared to 0.
- ARMED: every valid sample is written at the pointer, then the pointer increments modulo 2^ADDR_W. Wrap-around is continuous and the oldest data is overwritten.
- Trigger, evaluated on valid samples only:
  - Rising: prev < trig_level and sample_in >= trig_level.
  - Falling: prev >= trig_level and sample_in < trig_level.
  - The first valid sample after arm only loads prev and can never trigger.
- Force (ARMED) triggers on the next valid sample regardless of level.
- On the trigger sample:
  - The sample is written, trig_addr = its address, and the remaining counter = post_count.
  - If post_count = 0, go to DONE. Otherwise go to POST.
- POST: each valid sample is written and the counter decrements. The sample that brings the counter to 0 is the last one written, at trig_addr + post_count mod 2^ADDR_W. State then goes to DONE.
- DONE: no writes. Buffer and trig_addr are frozen.
- abort in any state -> IDLE with no writes. trig_addr is held.
- spi_rd_active has no effect on ARMED/POST. It only gates arm acceptance.

## Timing
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, trig_addr=0.
  - status=8'hA0.
  - Internal pointer, counter and prev are 0. History is invalid.
- Write latency is 1 cycle: a sample valid at edge n gives wr_en/wr_addr/wr_data registered and valid after edge n; the write is taken at edge n+1. wr_en is a single-cycle pulse per sample.
- A ctrl_stb accepted at edge n puts the new state in effect from cycle n+1. A sample_valid in the same cycle as an accepted arm is not written.
- Trigger decision and state change register at the same edge as the trigger sample's write registration. status.triggered/done follow one cycle later.
- Back-to-back sample_valid every cycle is supported with no gaps.
- rst_n assertion mid-capture clears everything immediately (async). The buffer contents are undefined to software.

## Structure
- Package acq_pkg holds:
  - State encoding localparams.
  - ctrl field bit positions (TRIG_LVL_LSB/MSB, ARM_BIT, ABORT_BIT, EDGE_BIT, FORCE_BIT, POST_LSB).
  - Status bit positions and the 4'hA ID nibble.
- Sub-module acq_trigger: registered prev sample, history-valid flag, edge/level compare and force. Outputs a combinational hit qualified by sample_valid.

## Test plan
- Reset, then idle samples: status=8'hA0, no wr_en. ctrl_stb with arm -> status=8'hA1, first write at addr 0.
- Rising edge, level=0x0800, post_count=4, ramp 0x07F0 step 1 from arm: trigger at sample 0x0800 (addr 16), trig_addr=16. Last write at addr 20. status=8'hA4 after completion.
- Wrap: level never reached for 5000 samples, then force with post_count=0xFFF: pointer wraps through 0. trig_addr = (5000) mod 4096 = 904. Final write at 903. DONE.
- Falling edge, post_count=0: trigger sample is the only post write, DONE the next cycle, no further wr_en.
- arm while spi_rd_active=1 in DONE: state stays DONE, status=8'hAC. A second arm with spi_rd_active=0 -> 8'hA1.
- Arm+abort in the same ctrl word during POST -> IDLE, wr_en stays low, trig_addr retains its value. Async reset mid-POST -> all outputs at reset values within the same cycle.
